// File: rtl/bin_to_bcd_iter_pkg.sv
// Shared constants for the iterative binary-to-BCD converter.
// Holds the FSM state encodings and the BCD digit width.
package bin_to_bcd_iter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_iter_add3.sv
// Double-dabble correction for a single BCD digit.
// Adds 3 when the digit is 5 or more, so that the following shift carries correctly.
module bcd_add3_digit
    import bin_to_bcd_iter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_adj_c
);

    assign digit_adj_c = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_iter.sv
// Iterative (shift-add-3) binary-to-BCD converter with valid/ready handshakes.
// It converts one bit per cycle, so the latency is fixed for a given N_BITS.
module bin_to_bcd_iter
    import bin_to_bcd_iter_pkg::*;
#(
    parameter int unsigned N_BITS   = 8,
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [N_BITS-1:0]     in_bin,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [4*N_DIGITS-1:0] out_bcd
);

    localparam int unsigned BCD_W   = DIGIT_W * N_DIGITS;
    localparam int unsigned CNT_W   = $clog2(N_BITS + 1);
    localparam int unsigned SHIFT_W = BCD_W + N_BITS;

    state_t               state;
    logic [N_BITS-1:0]    bin;
    logic [CNT_W-1:0]     cnt;
    logic [BCD_W-1:0]     bcd_adj_c;
    logic [SHIFT_W-1:0]   shift_c;

    // Per-digit add-3 correction applied to the live BCD register
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit       (out_bcd[DIGIT_W*g +: DIGIT_W]),
            .digit_adj_c (bcd_adj_c[DIGIT_W*g +: DIGIT_W])
        );
    end

    // The binary MSB moves into bit 0 of the ones digit
    assign shift_c = {bcd_adj_c, bin} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            out_bcd <= '0;
            bin     <= '0;
            cnt     <= '0;
            in_rdy  <= 1'b1;
            out_val <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_val) begin
                        bin     <= in_bin;
                        out_bcd <= '0;
                        cnt     <= CNT_W'(N_BITS);
                        state   <= ST_CONV;
                        in_rdy  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    out_bcd <= shift_c[SHIFT_W-1:N_BITS];
                    bin     <= shift_c[N_BITS-1:0];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= ST_DONE;
                        out_val <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        state   <= ST_IDLE;
                        out_val <= 1'b0;
                        in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    in_rdy  <= 1'b1;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
